// File: rtl/fp_alu_arbiter.sv
// fp_alu_arbiter: round-robin sharing of one fp_alu among NUM_REQ requesters; FP_ARB_STATS_EN adds stat_grants counters
module fp_alu (
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        gt
);
  function automatic logic [31:0] pack(input logic s, input logic signed [10:0] e, input logic [50:0] m);
    logic [50:0] n;
    logic [24:0] r;
    logic signed [10:0] er;
    int p;
    p = -1;
    for (int i = 0; i < 51; i++) if (m[i]) p = i;
    if (p < 0) return 32'h0;
    n = m << (50 - p);
    r = {1'b0, n[50:27]} + 25'(n[26] & (n[27] | (|n[25:0])));
    er = e + 11'(p - 49) + $signed({10'b0, r[24]});
    if (er >= 11'sd255) return {s, 8'hFF, 23'h0};
    if (er <= 11'sd0) return {s, 31'h0};
    return {s, er[7:0], r[24] ? r[23:1] : r[22:0]};
  endfunction
  logic [7:0] ea, eb, xe, ye, d;
  logic [23:0] ma, mb, xm, ym;
  logic sbe, xs, ys, swap, cmp;
  logic [50:0] xl, yl, sum;
  logic [47:0] prod;
  logic [31:0] add_r, mul_r;
  always_comb begin
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 0) ? 24'h0 : {1'b1, a[22:0]};
    mb = (eb == 0) ? 24'h0 : {1'b1, b[22:0]};
    sbe = b[31] ^ (op == 2'b01);
    swap = b[30:0] > a[30:0];
    {xs, xe, xm} = swap ? {sbe, eb, mb} : {a[31], ea, ma};
    {ys, ye, ym} = swap ? {a[31], ea, ma} : {sbe, eb, mb};
    d = xe - ye;
    xl = {1'b0, xm, 26'h0};
    yl = {1'b0, ym, 26'h0} >> d;
    sum = (xs == ys) ? xl + yl : xl - yl;
    add_r = pack(xs, $signed({3'b0, xe}), sum);
    prod = ma * mb;
    mul_r = pack(a[31] ^ b[31], $signed({3'b0, ea}) + $signed({3'b0, eb}) - 11'sd127, {prod, 3'b0});
    cmp = ((a[30:0] | b[30:0]) == 0) ? 1'b0 : (a[31] != b[31]) ? !a[31] :
          a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
    out = (op == 2'b11) ? b : (op == 2'b10) ? mul_r : add_r;
    gt = (op == 2'b11) & cmp;
  end
endmodule

module fp_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*2-1:0]  req_op,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [31:0]           resp_data,
  output logic                  resp_gt,
`ifdef FP_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0] stat_grants,
`endif
  output logic                  busy
);
  localparam int SW = IDW + 33;
  logic [IDW-1:0] rr_q, rr_d, g;
  logic gnt, alu_gt;
  logic [1:0] op_s;
  logic [31:0] a_s, b_s, alu_out;
  logic [LATENCY-1:0] v_q, v_d;
  logic [SW-1:0] st_q [LATENCY];
  logic [SW-1:0] st_d [LATENCY];
  always_comb begin
    gnt = 1'b0;
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        gnt = 1'b1;
        g = IDW'((int'(rr_q) + k) % NUM_REQ);
      end
    gnt = gnt & issue_en & ~rst;
    req_ready = gnt ? NUM_REQ'(1) << g : '0;
    rr_d = !gnt ? rr_q : (g == IDW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    op_s = req_op[2*g +: 2];
    a_s = req_a[32*g +: 32];
    b_s = req_b[32*g +: 32];
  end
  fp_alu u_alu (.op(op_s), .a(a_s), .b(b_s), .out(alu_out), .gt(alu_gt));
  always_comb begin
    v_d[0] = gnt;
    st_d[0] = gnt ? {g, alu_gt, alu_out} : st_q[0];
    for (int s = 1; s < LATENCY; s++) begin
      v_d[s] = v_q[s-1];
      st_d[s] = v_q[s-1] ? st_q[s-1] : st_q[s];
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rr_q <= '0;
      v_q <= '0;
      for (int s = 0; s < LATENCY; s++) st_q[s] <= '0;
    end else begin
      rr_q <= rr_d;
      v_q <= v_d;
      st_q <= st_d;
    end
  assign resp_valid = v_q[LATENCY-1];
  assign {resp_id, resp_gt, resp_data} = st_q[LATENCY-1];
  assign busy = |v_q;
`ifdef FP_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];
  always_comb
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = (req_ready[i] && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
      stat_grants[16*i +: 16] = cnt_q[i];
    end
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    else cnt_q <= cnt_d;
`endif
endmodule
